// File: rtl/utils_pkg.sv
// Shared types and constants for the UDP transmit path.
// Holds the FIFO pointer/length types and the transmit sequencer state encoding.
package utils_pkg;

  typedef logic [15:0] ptr_t;
  typedef logic [15:0] udp_length_t;

  typedef enum logic [2:0] {
    IDLE_TX_ST,
    WAIT_TX_ST,
    HDR_TX_ST,
    STREAM_TX_ST,
    DONE_TX_ST
  } udp_tx_st_t;

  localparam int MAX_UDP_PAYLOAD = 1472;
  localparam int UDP_HDR_BYTES   = 8;

endpackage

// File: rtl/udp_tx_ctrl.sv
// Transmit sequencer between the OutFIFO and the UDP stack: waits for a full payload,
// issues the header, streams the bytes through. Optional watchdog: UDP_TX_TIMEOUT_EN.
module udp_tx_ctrl
  import utils_pkg::*;
#(
  parameter int PTR_W       = 16,
  parameter int MAX_LEN     = MAX_UDP_PAYLOAD,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_i,
  input  logic [15:0]      len_i,
  input  logic [31:0]      dst_ip_i,
  input  logic [15:0]      src_port_i,
  input  logic [15:0]      dst_port_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [15:0]      pkt_cnt_o,
  input  logic [PTR_W-1:0] fifo_rd_ptr_i,
  input  logic [PTR_W-1:0] fifo_wr_ptr_i,
  input  logic             fifo_done_i,
  output logic             fifo_start_o,
  output logic [15:0]      fifo_len_o,
  output logic             fifo_clear_o,
  output logic             hdr_valid_o,
  input  logic             hdr_ready_i,
  output logic [31:0]      hdr_ip_dst_o,
  output logic [15:0]      hdr_src_port_o,
  output logic [15:0]      hdr_dst_port_o,
  output logic [15:0]      hdr_udp_len_o,
  input  logic [7:0]       s_tdata_i,
  input  logic             s_tvalid_i,
  input  logic             s_tlast_i,
  output logic             s_tready_o,
  output logic [7:0]       m_tdata_o,
  output logic             m_tvalid_o,
  output logic             m_tlast_o,
  input  logic             m_tready_i
);

  udp_tx_st_t  state_q, state_d;
  udp_length_t len_q, len_d;
  logic [31:0] ip_q, ip_d;
  logic [15:0] src_q, src_d, dst_q, dst_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic        mis_q, mis_d;
  logic        rej_q, rej_d;
  logic        abort_q;
  logic        timeout;

  logic [PTR_W-1:0] avail;
  logic             req_ok, beat, at_last, last_gen;

  // Pointer difference wraps naturally, so a wrapped write pointer still yields the fill level.
  assign avail    = fifo_wr_ptr_i - fifo_rd_ptr_i;
  assign req_ok   = (len_i != 16'd0) && (32'(len_i) <= 32'(MAX_LEN));
  assign beat     = (state_q == STREAM_TX_ST) && s_tvalid_i && m_tready_i;
  assign at_last  = (cnt_q == len_q - 16'd1);
  assign last_gen = s_tvalid_i && at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE_TX_ST;
      len_q     <= '0;
      ip_q      <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      cnt_q     <= '0;
      pkt_cnt_q <= '0;
      mis_q     <= 1'b0;
      rej_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      ip_q      <= ip_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      mis_q     <= mis_d;
      rej_q     <= rej_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    ip_d      = ip_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = '0;
    pkt_cnt_d = pkt_cnt_q;
    mis_d     = mis_q;
    rej_d     = 1'b0;
    case (state_q)
      IDLE_TX_ST: begin
        if (send_i) begin
          if (req_ok) begin
            len_d   = len_i;
            ip_d    = dst_ip_i;
            src_d   = src_port_i;
            dst_d   = dst_port_i;
            state_d = WAIT_TX_ST;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      WAIT_TX_ST: if (32'(avail) >= 32'(len_q)) state_d = HDR_TX_ST;
      HDR_TX_ST:  if (hdr_ready_i) state_d = STREAM_TX_ST;
      STREAM_TX_ST: begin
        cnt_d = beat ? cnt_q + 16'd1 : cnt_q;
        if (beat && (s_tlast_i != last_gen)) mis_d = 1'b1;
        if (fifo_done_i) state_d = DONE_TX_ST;
      end
      DONE_TX_ST: begin
        pkt_cnt_d = pkt_cnt_q + 16'd1;
        mis_d     = 1'b0;
        state_d   = IDLE_TX_ST;
      end
      default: state_d = IDLE_TX_ST;
    endcase
    if (timeout) begin
      state_d = IDLE_TX_ST;
      mis_d   = 1'b0;
    end
  end

  always_comb begin
    fifo_start_o   = 1'b0;
    fifo_len_o     = '0;
    hdr_valid_o    = 1'b0;
    hdr_ip_dst_o   = '0;
    hdr_src_port_o = '0;
    hdr_dst_port_o = '0;
    hdr_udp_len_o  = '0;
    m_tdata_o      = '0;
    m_tvalid_o     = 1'b0;
    m_tlast_o      = 1'b0;
    s_tready_o     = 1'b0;
    done_o         = 1'b0;
    err_o          = rej_q | abort_q;
    case (state_q)
      HDR_TX_ST: begin
        hdr_valid_o    = 1'b1;
        hdr_ip_dst_o   = ip_q;
        hdr_src_port_o = src_q;
        hdr_dst_port_o = dst_q;
        hdr_udp_len_o  = len_q + 16'(UDP_HDR_BYTES);
      end
      STREAM_TX_ST: begin
        fifo_start_o = 1'b1;
        fifo_len_o   = len_q;
        m_tdata_o    = s_tdata_i;
        m_tvalid_o   = s_tvalid_i;
        m_tlast_o    = last_gen;
        s_tready_o   = m_tready_i;
      end
      DONE_TX_ST: begin
        done_o = 1'b1;
        err_o  = rej_q | abort_q | mis_q;
      end
      default: ;
    endcase
  end

  assign busy_o       = (state_q != IDLE_TX_ST);
  assign pkt_cnt_o    = pkt_cnt_q;
  assign fifo_clear_o = abort_q;

`ifdef UDP_TX_TIMEOUT_EN
  logic [31:0] wd_q, wd_d;
  logic        counting;

  assign counting = (state_q == WAIT_TX_ST) || (state_q == HDR_TX_ST) || (state_q == STREAM_TX_ST);
  assign timeout  = counting && !beat && (wd_q == 32'(TIMEOUT_CYC - 1));

  // Any forward progress (state change or payload beat) restarts the watchdog.
  always_comb begin
    wd_d = wd_q + 32'd1;
    if (!counting || (state_d != state_q) || beat) wd_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q    <= '0;
      abort_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      abort_q <= timeout;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign abort_q            = 1'b0;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
`endif

endmodule

// File: tb/tb_udp_tx_ctrl.sv
// Self-checking bench for udp_tx_ctrl: request-validation table, directed packet
// sequences and randomized packets checked against a transaction-level model.
module tb_udp_tx_ctrl;
  import utils_pkg::*;

`ifdef UDP_TX_TIMEOUT_EN
  localparam int TO_CYC = 100;
`else
  localparam int TO_CYC = 65535;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        send_i = 1'b0;
  logic [15:0] len_i = '0;
  logic [31:0] dst_ip_i = '0;
  logic [15:0] src_port_i = '0, dst_port_i = '0;
  logic        busy_o, done_o, err_o;
  logic [15:0] pkt_cnt_o;
  logic [15:0] fifo_rd_ptr_i = '0, fifo_wr_ptr_i = '0;
  logic        fifo_done_i = 1'b0;
  logic        fifo_start_o, fifo_clear_o;
  logic [15:0] fifo_len_o;
  logic        hdr_valid_o;
  logic        hdr_ready_i = 1'b0;
  logic [31:0] hdr_ip_dst_o;
  logic [15:0] hdr_src_port_o, hdr_dst_port_o, hdr_udp_len_o;
  logic [7:0]  s_tdata_i = '0;
  logic        s_tvalid_i = 1'b0, s_tlast_i = 1'b0;
  logic        s_tready_o;
  logic [7:0]  m_tdata_o;
  logic        m_tvalid_o, m_tlast_o;
  logic        m_tready_i = 1'b0;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_pkt = '0;

  typedef struct {
    int len;
    bit exp_err;
    bit exp_busy;
  } req_vec_t;

  req_vec_t vecs[6];

  always #5 clk = ~clk;

  udp_tx_ctrl #(
    .PTR_W(16), .MAX_LEN(MAX_UDP_PAYLOAD), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .send_i(send_i), .len_i(len_i), .dst_ip_i(dst_ip_i),
    .src_port_i(src_port_i), .dst_port_i(dst_port_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .pkt_cnt_o(pkt_cnt_o), .fifo_rd_ptr_i(fifo_rd_ptr_i),
    .fifo_wr_ptr_i(fifo_wr_ptr_i), .fifo_done_i(fifo_done_i), .fifo_start_o(fifo_start_o),
    .fifo_len_o(fifo_len_o), .fifo_clear_o(fifo_clear_o), .hdr_valid_o(hdr_valid_o),
    .hdr_ready_i(hdr_ready_i), .hdr_ip_dst_o(hdr_ip_dst_o), .hdr_src_port_o(hdr_src_port_o),
    .hdr_dst_port_o(hdr_dst_port_o), .hdr_udp_len_o(hdr_udp_len_o), .s_tdata_i(s_tdata_i),
    .s_tvalid_i(s_tvalid_i), .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o),
    .m_tdata_o(m_tdata_o), .m_tvalid_o(m_tvalid_o), .m_tlast_o(m_tlast_o),
    .m_tready_i(m_tready_i)
  );

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int len, input logic [31:0] ip, input logic [15:0] sp,
                               input logic [15:0] dp);
    send_i     = 1'b1;
    len_i      = 16'(len);
    dst_ip_i   = ip;
    src_port_i = sp;
    dst_port_i = dp;
    tick();
    send_i = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One full transaction: the bench plays the OutFIFO source and the UDP sink, and the
  // expected header/payload/count come from the packet parameters alone.
  task automatic run_packet(input int len, input logic [15:0] base, input int init_avail,
                            input int hdr_delay, input int ready_pct, input bit bad_last,
                            input bit poke_send, input logic [15:0] sp, input logic [15:0] dp);
    logic [7:0]  src[$];
    logic [7:0]  rx[$];
    logic [31:0] ip;
    int          idx;
    int          guard;
    int          waited;
    ip     = $urandom();
    idx    = 0;
    guard  = 0;
    waited = 0;
    for (int i = 0; i < len; i++) src.push_back(8'($urandom()));
    fifo_rd_ptr_i = base;
    fifo_wr_ptr_i = base + 16'(init_avail);
    applyStimulus(len, ip, sp, dp);
    checkOutput("busy_after_send", 32'(busy_o), 32'd1);
    checkOutput("err_after_send", 32'(err_o), 32'd0);
    if (init_avail < len) begin
      for (int i = 0; i < 10; i++) begin
        checkOutput("hdr_valid_while_waiting", 32'(hdr_valid_o), 32'd0);
        tick();
      end
      fifo_wr_ptr_i = base + 16'(len);
    end
    while (!hdr_valid_o && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("hdr_valid_reached", 32'(hdr_valid_o), 32'd1);
    if (!hdr_valid_o) begin
      pulse_reset();
      exp_pkt = '0;
      return;
    end
    for (int d = 0; d <= hdr_delay; d++) begin
      checkOutput("hdr_valid_held", 32'(hdr_valid_o), 32'd1);
      checkOutput("hdr_ip", hdr_ip_dst_o, ip);
      checkOutput("hdr_src_port", 32'(hdr_src_port_o), 32'(sp));
      checkOutput("hdr_dst_port", 32'(hdr_dst_port_o), 32'(dp));
      checkOutput("hdr_udp_len", 32'(hdr_udp_len_o), 32'((len + UDP_HDR_BYTES) % 65536));
      checkOutput("start_before_stream", 32'(fifo_start_o), 32'd0);
      hdr_ready_i = (d == hdr_delay);
      tick();
    end
    hdr_ready_i = 1'b0;
    checkOutput("hdr_valid_drops", 32'(hdr_valid_o), 32'd0);
    while (rx.size() < len && guard < len * 6 + 100) begin
      s_tvalid_i = (idx < len) && ($urandom_range(0, 3) != 0);
      s_tdata_i  = (idx < len) ? src[idx] : 8'($urandom());
      s_tlast_i  = bad_last ? (idx == len - 2) : (idx == len - 1);
      m_tready_i = ($urandom_range(0, 99) < ready_pct);
      send_i     = poke_send && (guard == 3);
      len_i      = 16'd0;
      #1;
      checkOutput("stream_start", 32'(fifo_start_o), 32'd1);
      checkOutput("stream_len", 32'(fifo_len_o), 32'(len));
      checkOutput("stream_busy", 32'(busy_o), 32'd1);
      checkOutput("stream_err", 32'(err_o), 32'd0);
      checkOutput("m_tvalid_pass", 32'(m_tvalid_o), 32'(s_tvalid_i));
      checkOutput("s_tready_pass", 32'(s_tready_o), 32'(m_tready_i));
      checkOutput("m_tlast", 32'(m_tlast_o), 32'(s_tvalid_i && (idx == len - 1)));
      if (m_tvalid_o && m_tready_i) rx.push_back(m_tdata_o);
      if (s_tvalid_i && s_tready_o) idx++;
      guard++;
      tick();
    end
    send_i     = 1'b0;
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
    m_tready_i = 1'b0;
    checkOutput("payload_count", 32'(rx.size()), 32'(len));
    for (int i = 0; i < rx.size() && i < len; i++)
      checkOutput("payload_byte", 32'(rx[i]), 32'(src[i]));
    fifo_done_i = 1'b1;
    tick();
    fifo_done_i = 1'b0;
    checkOutput("done_pulse", 32'(done_o), 32'd1);
    checkOutput("done_err", 32'(err_o), 32'(bad_last));
    checkOutput("done_start_released", 32'(fifo_start_o), 32'd0);
    checkOutput("done_clear", 32'(fifo_clear_o), 32'd0);
    exp_pkt = exp_pkt + 16'd1;
    tick();
    checkOutput("done_single", 32'(done_o), 32'd0);
    checkOutput("err_after_done", 32'(err_o), 32'd0);
    checkOutput("idle_after_done", 32'(busy_o), 32'd0);
    checkOutput("pkt_cnt", 32'(pkt_cnt_o), 32'(exp_pkt));
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL global_time_limit: got no finish, expected finish before limit");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    vecs[0] = '{len: 0,     exp_err: 1'b1, exp_busy: 1'b0};
    vecs[1] = '{len: 1473,  exp_err: 1'b1, exp_busy: 1'b0};
    vecs[2] = '{len: 65535, exp_err: 1'b1, exp_busy: 1'b0};
    vecs[3] = '{len: 1,     exp_err: 1'b0, exp_busy: 1'b1};
    vecs[4] = '{len: 1472,  exp_err: 1'b0, exp_busy: 1'b1};
    vecs[5] = '{len: 4,     exp_err: 1'b0, exp_busy: 1'b1};

    tick();
    tick();
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
    checkOutput("rst_fifo_start", 32'(fifo_start_o), 32'd0);
    checkOutput("rst_fifo_len", 32'(fifo_len_o), 32'd0);
    checkOutput("rst_fifo_clear", 32'(fifo_clear_o), 32'd0);
    checkOutput("rst_hdr_valid", 32'(hdr_valid_o), 32'd0);
    checkOutput("rst_hdr_len", 32'(hdr_udp_len_o), 32'd0);
    checkOutput("rst_m_tvalid", 32'(m_tvalid_o), 32'd0);
    checkOutput("rst_s_tready", 32'(s_tready_o), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].len, 32'h0a000001, 16'd100, 16'd200);
      checkOutput("req_err", 32'(err_o), 32'(vecs[i].exp_err));
      checkOutput("req_busy", 32'(busy_o), 32'(vecs[i].exp_busy));
      tick();
      checkOutput("req_err_single", 32'(err_o), 32'd0);
      if (vecs[i].exp_busy) pulse_reset();
    end

    run_packet(4, 16'h0000, 4, 0, 100, 1'b0, 1'b0, 16'd1234, 16'd5678);
    run_packet(16, 16'h0100, 8, 0, 100, 1'b0, 1'b0, 16'd10, 16'd20);
    run_packet(32, 16'hFFF0, 32, 0, 100, 1'b0, 1'b0, 16'd30, 16'd40);
    run_packet(40, 16'h2000, 40, 5, 50, 1'b0, 1'b1, 16'd50, 16'd60);
    run_packet(6, 16'h3000, 6, 1, 80, 1'b1, 1'b0, 16'd70, 16'd80);
    for (int p = 0; p < 6; p++) begin
      int plen;
      plen = $urandom_range(1, 64);
      run_packet(plen, 16'($urandom()), ($urandom_range(0, 1) != 0) ? plen : $urandom_range(0, plen - 1),
                 $urandom_range(0, 4), $urandom_range(30, 100), 1'b0, 1'b0,
                 16'($urandom()), 16'($urandom()));
    end
    run_packet(MAX_UDP_PAYLOAD, 16'h1234, MAX_UDP_PAYLOAD, 1, 100, 1'b0, 1'b0, 16'd7, 16'd9);

    // Reset while streaming must drop the FIFO command without a clear pulse.
    fifo_rd_ptr_i = 16'h0000;
    fifo_wr_ptr_i = 16'h0008;
    hdr_ready_i   = 1'b1;
    applyStimulus(8, 32'hc0a80001, 16'd1, 16'd2);
    for (int i = 0; i < 10 && !fifo_start_o; i++) tick();
    hdr_ready_i = 1'b0;
    checkOutput("mid_start_streaming", 32'(fifo_start_o), 32'd1);
    s_tvalid_i = 1'b1;
    m_tready_i = 1'b1;
    tick();
    tick();
    pulse_reset();
    s_tvalid_i = 1'b0;
    m_tready_i = 1'b0;
    exp_pkt    = '0;
    checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("mid_rst_start", 32'(fifo_start_o), 32'd0);
    checkOutput("mid_rst_clear", 32'(fifo_clear_o), 32'd0);
    checkOutput("mid_rst_m_tvalid", 32'(m_tvalid_o), 32'd0);
    checkOutput("mid_rst_pkt_cnt", 32'(pkt_cnt_o), 32'(exp_pkt));

`ifdef UDP_TX_TIMEOUT_EN
    begin
      int n;
      run_packet(4, 16'h0040, 4, 0, 100, 1'b0, 1'b0, 16'd3, 16'd4);
      fifo_rd_ptr_i = 16'h0500;
      fifo_wr_ptr_i = 16'h0500;
      applyStimulus(16, 32'h01020304, 16'd5, 16'd6);
      n = 1;
      while (!fifo_clear_o && n < 300) begin
        tick();
        n++;
      end
      checkOutput("timeout_window", 32'((n >= TO_CYC - 5) && (n <= TO_CYC + 5)), 32'd1);
      checkOutput("timeout_clear", 32'(fifo_clear_o), 32'd1);
      checkOutput("timeout_err", 32'(err_o), 32'd1);
      checkOutput("timeout_idle", 32'(busy_o), 32'd0);
      checkOutput("timeout_start", 32'(fifo_start_o), 32'd0);
      tick();
      checkOutput("timeout_clear_single", 32'(fifo_clear_o), 32'd0);
      checkOutput("timeout_err_single", 32'(err_o), 32'd0);
      checkOutput("timeout_pkt_cnt", 32'(pkt_cnt_o), 32'(exp_pkt));
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
